multi_input_conditioner: RTL and testbench

MULTI_INPUT_CONDITIONER -- requirements
Module: multi_input_conditioner

---
 rtl/multi_input_conditioner.sv | 138 +++++++++++++
 tb/tb_multi_input_conditioner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner
//   Conditions CHANNELS independent asynchronous inputs. Each channel has its
//   own synchronizer chain, a debounce counter compared against a shared
//   runtime delay, a debounced level and one-clock rise/fall pulses.
//
//   Optional feature macro: MULTI_COND_EDGE_STATUS_EN
//     defined   -> sticky per-channel edge flags (write-1-to-clear) and irq
//     undefined -> edge_status and irq tie to 0 and no status flops exist
//
//   Reset is synchronous and active-low (reset_n sampled on posedge clk).
module multi_input_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNELS-1:0]      noisysignal,
    input  logic [COUNTER_WIDTH-1:0] waittime,
    input  logic [CHANNELS-1:0]      status_clr,
    output logic [CHANNELS-1:0]      conditioned,
    output logic [CHANNELS-1:0]      positiveedge,
    output logic [CHANNELS-1:0]      negativeedge,
    output logic                     any_posedge,
    output logic                     any_negedge,
    output logic [CHANNELS-1:0]      edge_status,
    output logic                     irq
);

    // Increment step for the debounce counter, sized to the counter itself.
    localparam logic [COUNTER_WIDTH-1:0] CountOne = COUNTER_WIDTH'(1);

    // One fully independent conditioning slice per input channel.
    genvar ch;
    generate
        for (ch = 0; ch < CHANNELS; ch++) begin : gChannel
            logic [SYNC_STAGES-1:0]   sync_q;
            logic [SYNC_STAGES-1:0]   sync_d;
            logic [COUNTER_WIDTH-1:0] count_q;
            logic [COUNTER_WIDTH-1:0] count_d;
            logic                     level_q;
            logic                     level_d;
            logic                     rise_q;
            logic                     rise_d;
            logic                     fall_q;
            logic                     fall_d;
            logic                     syncedLevel;
            logic                     levelDiffers;
            logic                     delayElapsed;

            // The last synchronizer stage is the only safe view of the raw input.
            assign syncedLevel  = sync_q[SYNC_STAGES-1];
            assign levelDiffers = (syncedLevel != level_q);
            // The counter only increments while below waittime, so this compare
            // always fires before the counter could wrap. A lowered waittime
            // takes effect immediately because the compare is live every edge.
            assign delayElapsed = (count_q >= waittime);

            // Shift the raw input one stage further down the synchronizer chain.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], noisysignal[ch]};
            end

            // Debounce decision: accept the synced level once it has disagreed
            // with the current level for longer than waittime, otherwise count.
            // Any return to agreement restarts the count from zero.
            always_comb begin
                count_d = '0;
                level_d = level_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (levelDiffers) begin
                    if (delayElapsed) begin
                        level_d = syncedLevel;
                        rise_d  = syncedLevel;
                        fall_d  = ~syncedLevel;
                    end else begin
                        count_d = count_q + CountOne;
                    end
                end
            end

            // Channel state; reset drops everything to 0 without producing a pulse.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync_q  <= '0;
                    count_q <= '0;
                    level_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    count_q <= count_d;
                    level_q <= level_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign conditioned[ch]  = level_q;
            assign positiveedge[ch] = rise_q;
            assign negativeedge[ch] = fall_q;
        end
    endgenerate

`ifdef MULTI_COND_EDGE_STATUS_EN
    logic [CHANNELS-1:0] status_q;
    logic [CHANNELS-1:0] status_d;

    // Sticky flags: a pulse sets, status_clr clears, and set wins a tie so a
    // clear racing a fresh edge never loses that edge.
    always_comb begin
        status_d = (status_q & ~status_clr) | positiveedge | negativeedge;
    end

    // Flag registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign edge_status = status_q;
    assign irq         = |status_q;
`else
    // Feature absent: status_clr is intentionally ignored.
    logic unusedStatusClr;
    assign unusedStatusClr = ^status_clr;
    assign edge_status     = '0;
    assign irq             = 1'b0;
`endif

    assign any_posedge = |positiveedge;
    assign any_negedge = |negativeedge;

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Testbench for multi_input_conditioner (default parameters).
// Directed vector table, hand-written corner sequences and a randomized run,
// all checked against a behavioural model of the debounce rules.
module tb_multi_input_conditioner;

    localparam int CH = 4;
    localparam int CW = 3;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] noisysignal;
    logic [CW-1:0] waittime;
    logic [CH-1:0] status_clr;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positiveedge;
    logic [CH-1:0] negativeedge;
    logic          any_posedge;
    logic          any_negedge;
    logic [CH-1:0] edge_status;
    logic          irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rstN;
        logic [CH-1:0] noisy;
        logic [CW-1:0] waitT;
        logic [CH-1:0] clr;
        logic [CH-1:0] expCond;
        logic [CH-1:0] expPos;
        logic [CH-1:0] expNeg;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    logic [CH-1:0] mHist[SS];   // mHist[0] = raw sample from the previous edge
    logic [CH-1:0] mCond;
    logic [CH-1:0] mPos;
    logic [CH-1:0] mNeg;
    logic [CH-1:0] mStatus;
    int            mRun[CH];    // consecutive edges the synced input disagreed

    logic [CH-1:0] target;
    logic [CH-1:0] glitch;
    logic [CW-1:0] wtRand;

    always #5 clk = ~clk;

    multi_input_conditioner #(
        .CHANNELS(CH),
        .COUNTER_WIDTH(CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .noisysignal(noisysignal),
        .waittime(waittime),
        .status_clr(status_clr),
        .conditioned(conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .any_posedge(any_posedge),
        .any_negedge(any_negedge),
        .edge_status(edge_status),
        .irq(irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic [CH-1:0] noisy,
                                 input logic [CW-1:0] wt, input logic [CH-1:0] clr);
        reset_n     = rstN;
        noisysignal = noisy;
        waittime    = wt;
        status_clr  = clr;
    endtask

    // Level changes once the delayed input has disagreed for more than
    // waittime consecutive edges; pulses last exactly the following cycle.
    task automatic modelStep();
        logic [CH-1:0] s;
        logic [CH-1:0] nPos;
        logic [CH-1:0] nNeg;
        if (!reset_n) begin
            for (int k = 0; k < SS; k++) mHist[k] = '0;
            for (int c = 0; c < CH; c++) mRun[c] = 0;
            mCond   = '0;
            mPos    = '0;
            mNeg    = '0;
            mStatus = '0;
        end else begin
            s    = mHist[SS-1];
            nPos = '0;
            nNeg = '0;
            for (int c = 0; c < CH; c++) begin
                if (s[c] == mCond[c]) begin
                    mRun[c] = 0;
                end else if (mRun[c] >= int'(waittime)) begin
                    mCond[c] = s[c];
                    if (s[c]) nPos[c] = 1'b1;
                    else      nNeg[c] = 1'b1;
                    mRun[c] = 0;
                end else begin
                    mRun[c] = mRun[c] + 1;
                end
            end
`ifdef MULTI_COND_EDGE_STATUS_EN
            for (int c = 0; c < CH; c++) begin
                if (mPos[c] || mNeg[c]) mStatus[c] = 1'b1;
                else if (status_clr[c]) mStatus[c] = 1'b0;
            end
`endif
            mPos = nPos;
            mNeg = nNeg;
            for (int k = SS - 1; k > 0; k--) mHist[k] = mHist[k-1];
            mHist[0] = noisysignal;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model.cond", 32'(conditioned), 32'(mCond));
        checkOutput("model.edges", 32'({any_posedge, any_negedge, positiveedge, negativeedge}),
                    32'({|mPos, |mNeg, mPos, mNeg}));
        checkOutput("model.status", 32'({irq, edge_status}), 32'({|mStatus, mStatus}));
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 3'd3, '0);
        tick();
        tick();
    endtask

    function automatic void pushVec(input logic rstN, input logic [CH-1:0] noisy, input logic [CW-1:0] wt,
                                    input logic [CH-1:0] cond, input logic [CH-1:0] pos, input logic [CH-1:0] neg);
        vec_t v;
        v.rstN = rstN; v.noisy = noisy; v.waitT = wt; v.clr = '0;
        v.expCond = cond; v.expPos = pos; v.expNeg = neg;
        vecs.push_back(v);
    endfunction

    initial begin
        applyStimulus(1'b0, '0, 3'd3, '0);
        target = '0;
        glitch = '0;
        wtRand = 3'd3;

        // Reset state
        tick();
        checkOutput("reset.cond", 32'(conditioned), 32'(0));
        checkOutput("reset.edges", 32'({positiveedge, negativeedge}), 32'(0));
        checkOutput("reset.status", 32'({irq, edge_status}), 32'(0));

        // Directed table: ch0 step, ch1 3-clock glitch, ch1 6-clock pulse
        pushVec(1'b0, 4'h0, 3'd3, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 5; i++)  pushVec(1'b1, 4'h1, 3'd3, 4'h0, 4'h0, 4'h0);
        pushVec(1'b1, 4'h1, 3'd3, 4'h1, 4'h1, 4'h0);
        pushVec(1'b1, 4'h1, 3'd3, 4'h1, 4'h0, 4'h0);
        for (int i = 8; i <= 10; i++)  pushVec(1'b1, 4'h3, 3'd3, 4'h1, 4'h0, 4'h0);
        for (int i = 11; i <= 14; i++) pushVec(1'b1, 4'h1, 3'd3, 4'h1, 4'h0, 4'h0);
        for (int i = 15; i <= 19; i++) pushVec(1'b1, 4'h3, 3'd3, 4'h1, 4'h0, 4'h0);
        pushVec(1'b1, 4'h3, 3'd3, 4'h3, 4'h2, 4'h0);
        for (int i = 21; i <= 25; i++) pushVec(1'b1, 4'h1, 3'd3, 4'h3, 4'h0, 4'h0);
        pushVec(1'b1, 4'h1, 3'd3, 4'h1, 4'h0, 4'h2);
        pushVec(1'b1, 4'h1, 3'd3, 4'h1, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].noisy, vecs[i].waitT, vecs[i].clr);
            tick();
            checkOutput($sformatf("vec%0d.cond", i), 32'(conditioned), 32'(vecs[i].expCond));
            checkOutput($sformatf("vec%0d.edges", i), 32'({positiveedge, negativeedge}),
                        32'({vecs[i].expPos, vecs[i].expNeg}));
        end

        // waittime=0: ch2 rises and falls on the third edge after the change
        doReset();
        applyStimulus(1'b1, 4'h4, 3'd0, '0);
        tick(); tick(); tick();
        checkOutput("wt0.rise", 32'({conditioned[2], positiveedge[2]}), 32'(2'b11));
        tick();
        applyStimulus(1'b1, 4'h0, 3'd0, '0);
        tick(); tick();
        checkOutput("wt0.hold", 32'(conditioned[2]), 32'(1));
        tick();
        checkOutput("wt0.fall", 32'({conditioned[2], negativeedge[2]}), 32'(2'b01));

        // Lowering waittime mid-count on ch3 triggers on the next edge
        doReset();
        applyStimulus(1'b1, 4'h8, 3'd7, '0);
        tick(); tick(); tick(); tick();
        checkOutput("wtdrop.before", 32'(conditioned[3]), 32'(0));
        applyStimulus(1'b1, 4'h8, 3'd1, '0);
        tick();
        checkOutput("wtdrop.after", 32'({conditioned[3], positiveedge[3]}), 32'(2'b11));

        // Reset mid-count on ch0 discards the pending change
        doReset();
        applyStimulus(1'b1, 4'h1, 3'd3, '0);
        tick(); tick(); tick(); tick();
        applyStimulus(1'b0, 4'h1, 3'd3, '0);
        tick();
        checkOutput("midreset.outs", 32'({conditioned, positiveedge, negativeedge}), 32'(0));
        applyStimulus(1'b1, 4'h1, 3'd3, '0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("midreset.wait", 32'(conditioned[0]), 32'(0));
        tick();
        checkOutput("midreset.rise", 32'({conditioned[0], positiveedge[0]}), 32'(2'b11));

`ifdef MULTI_COND_EDGE_STATUS_EN
        // Sticky status: set, set-beats-clear, then clear alone
        doReset();
        applyStimulus(1'b1, 4'h2, 3'd0, '0);
        tick(); tick(); tick();
        applyStimulus(1'b1, 4'h0, 3'd0, '0);
        tick();
        checkOutput("status.set", 32'({irq, edge_status[1]}), 32'(2'b11));
        tick(); tick();
        checkOutput("status.newpulse", 32'(negativeedge[1]), 32'(1));
        applyStimulus(1'b1, 4'h0, 3'd0, 4'h2);
        tick();
        checkOutput("status.setwins", 32'(edge_status[1]), 32'(1));
        tick();
        checkOutput("status.cleared", 32'({irq, edge_status[1]}), 32'(0));
        applyStimulus(1'b1, 4'h0, 3'd0, '0);
`else
        // Without the feature status stays 0 even after edges and clears
        doReset();
        applyStimulus(1'b1, 4'h2, 3'd0, 4'hF);
        tick(); tick(); tick(); tick();
        checkOutput("nostatus", 32'({irq, edge_status}), 32'(0));
`endif

        // Randomized run against the model
        doReset();
        target = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) target[c] = ~target[c];
            end
            glitch = CH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) wtRand = CW'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 199) != 0), target ^ glitch, wtRand,
                          ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
